// File: rtl/l2_core_arb_if.sv
// Bundle of core-side request slots and the shared L2 request port for l2_core_arb.
// slave = arbiter view, master = the cores + L2 pipeline view.
interface l2_core_arb_if #(
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = 2
) ();
  logic [NUM_CORES-1:0]     core_l2req_valid;
  logic [NUM_CORES-1:0]     core_l2req_ready;
  logic [2*NUM_CORES-1:0]   core_l2req_unit;
  logic [2*NUM_CORES-1:0]   core_l2req_strand;
  logic [3*NUM_CORES-1:0]   core_l2req_op;
  logic [2*NUM_CORES-1:0]   core_l2req_way;
  logic [26*NUM_CORES-1:0]  core_l2req_address;
  logic [512*NUM_CORES-1:0] core_l2req_data;
  logic [64*NUM_CORES-1:0]  core_l2req_mask;

  logic                     l2req_ready;
  logic                     l2req_valid;
  logic [CORE_ID_WIDTH-1:0] l2req_core;
  logic [1:0]               l2req_unit;
  logic [1:0]               l2req_strand;
  logic [2:0]               l2req_op;
  logic [1:0]               l2req_way;
  logic [25:0]              l2req_address;
  logic [511:0]             l2req_data;
  logic [63:0]              l2req_mask;

  modport slave (
    input  core_l2req_valid, core_l2req_unit, core_l2req_strand, core_l2req_op,
           core_l2req_way, core_l2req_address, core_l2req_data, core_l2req_mask,
           l2req_ready,
    output core_l2req_ready, l2req_valid, l2req_core, l2req_unit, l2req_strand,
           l2req_op, l2req_way, l2req_address, l2req_data, l2req_mask
  );

  modport master (
    output core_l2req_valid, core_l2req_unit, core_l2req_strand, core_l2req_op,
           core_l2req_way, core_l2req_address, core_l2req_data, core_l2req_mask,
           l2req_ready,
    input  core_l2req_ready, l2req_valid, l2req_core, l2req_unit, l2req_strand,
           l2req_op, l2req_way, l2req_address, l2req_data, l2req_mask
  );
endinterface

// File: rtl/l2_core_arb.sv
// Round-robin arbiter: one holding slot per core feeding a registered L2 request stage.
// Define L2_CORE_ARB_PERF_EN to add per-core grant counters and an output stall counter.
module l2_core_arb #(
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = 2
) (
  input  logic clk,
  input  logic reset,
  l2_core_arb_if.slave bus
`ifdef L2_CORE_ARB_PERF_EN
  ,
  output logic [32*NUM_CORES-1:0] perf_grant_count,
  output logic [31:0]             perf_stall_count
`endif
);
  localparam int CW = CORE_ID_WIDTH;

  typedef struct packed {
    logic [1:0]   unit;
    logic [1:0]   strand;
    logic [2:0]   op;
    logic [1:0]   way;
    logic [25:0]  address;
    logic [511:0] data;
    logic [63:0]  mask;
  } req_t;

  logic [NUM_CORES-1:0] slot_valid_q, slot_valid_d;
  req_t [NUM_CORES-1:0] slot_q, slot_d;
  req_t [NUM_CORES-1:0] core_req;
  logic                 out_valid_q, out_valid_d;
  req_t                 out_q, out_d;
  logic [CW-1:0]        out_core_q, out_core_d;
  logic [CW-1:0]        rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0] accept;
  logic                 out_free;
  logic                 grant;
  logic                 win_found;
  logic [CW-1:0]        win_idx;
  logic [CW:0]          cand;
  logic [CW:0]          nxt;

  always_comb begin
    core_req = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_req[i].unit    = bus.core_l2req_unit[2*i +: 2];
      core_req[i].strand  = bus.core_l2req_strand[2*i +: 2];
      core_req[i].op      = bus.core_l2req_op[3*i +: 3];
      core_req[i].way     = bus.core_l2req_way[2*i +: 2];
      core_req[i].address = bus.core_l2req_address[26*i +: 26];
      core_req[i].data    = bus.core_l2req_data[512*i +: 512];
      core_req[i].mask    = bus.core_l2req_mask[64*i +: 64];
    end
  end

  // Slot ready comes straight from its flop, so cores never see l2req_ready combinationally.
  assign accept   = bus.core_l2req_valid & ~slot_valid_q;
  assign out_free = !out_valid_q || bus.l2req_ready;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (cand >= (CW+1)'(NUM_CORES)) cand = cand - (CW+1)'(NUM_CORES);
      if (!win_found && slot_valid_q[cand[CW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[CW-1:0];
      end
    end
  end

  assign grant = out_free && win_found;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    out_core_d   = out_core_q;
    rr_ptr_d     = rr_ptr_q;
    nxt          = {1'b0, win_idx} + (CW+1)'(1);
    if (nxt >= (CW+1)'(NUM_CORES)) nxt = '0;

    if (grant) begin
      out_valid_d           = 1'b1;
      out_d                 = slot_q[win_idx];
      out_core_d            = win_idx;
      slot_valid_d[win_idx] = 1'b0;
      rr_ptr_d              = nxt[CW-1:0];
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end

    // A granted slot cannot be accepting this cycle: its ready was low.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (accept[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_d[i]       = core_req[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid_q <= '0;
      slot_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_core_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      out_core_q   <= out_core_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.core_l2req_ready = ~slot_valid_q;
  assign bus.l2req_valid      = out_valid_q;
  assign bus.l2req_core       = out_core_q;
  assign bus.l2req_unit       = out_q.unit;
  assign bus.l2req_strand     = out_q.strand;
  assign bus.l2req_op         = out_q.op;
  assign bus.l2req_way        = out_q.way;
  assign bus.l2req_address    = out_q.address;
  assign bus.l2req_data       = out_q.data;
  assign bus.l2req_mask       = out_q.mask;

`ifdef L2_CORE_ARB_PERF_EN
  logic [NUM_CORES-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]                stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (grant) grant_cnt_d[win_idx] = grant_cnt_q[win_idx] + 32'd1;
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !bus.l2req_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_grant_count = grant_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`endif
endmodule
